// File: rtl/pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// pipe_stage_elastic : valid/ready pipeline register, optional skid entry,
//                      synchronous flush, saturating stall counter. Rev 1.0
// ============================================================================
module pipe_stage_elastic #(
   parameter int DATA_W  = 32,
   parameter int SKID_EN = 1,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   // Encoding doubles as the entry count driven on occupancy.
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [DATA_W-1:0] main_q;
   logic [DATA_W-1:0] skid_q;
   logic              accept;
   logic              take;
   logic              main_load;
   logic              main_from_skid;
   logic              skid_load;
   logic              stall;

   assign out_valid = (state != S_EMPTY);
   assign out_data  = main_q;
   assign occupancy = state;
   assign accept    = in_valid && in_ready;
   assign take      = out_valid && out_ready;
   assign stall     = out_valid && !out_ready;

   generate
      if (SKID_EN != 0) begin : g_skid_ready
         // Ready depends only on registered state: no out_ready -> in_ready path.
         assign in_ready = !rst && !flush && (state != S_TWO);
      end else begin : g_pass_ready
         assign in_ready = !rst && !flush && (!out_valid || out_ready);
      end
   endgenerate

   always_comb begin
      state_nxt      = state;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      if (flush) begin
         state_nxt = S_EMPTY;
      end else begin
         case (state)
            S_EMPTY: begin
               if (accept) begin
                  state_nxt = S_ONE;
                  main_load = 1'b1;
               end
            end
            S_ONE: begin
               if (accept && take) begin
                  main_load = 1'b1;
               end else if (accept) begin
                  state_nxt = S_TWO;
                  skid_load = 1'b1;
               end else if (take) begin
                  state_nxt = S_EMPTY;
               end
            end
            S_TWO: begin
               if (take) begin
                  state_nxt      = S_ONE;
                  main_from_skid = 1'b1;
               end
            end
            default: state_nxt = S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_EMPTY;
         main_q <= '0;
      end else begin
         state <= state_nxt;
         if (main_load) begin
            main_q <= in_data;
         end else if (main_from_skid) begin
            main_q <= skid_q;
         end
      end
   end

   generate
      if (SKID_EN != 0) begin : g_skid
         always_ff @(posedge clk) begin
            if (rst) begin
               skid_q <= '0;
            end else if (skid_load) begin
               skid_q <= in_data;
            end
         end
      end else begin : g_no_skid
         assign skid_q = '0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// tb_pipe_stage_elastic : directed vector bench for pipe_stage_elastic. Rev 1.0
// ============================================================================
module tb_pipe_stage_elastic;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;

   logic        m_ir, m_ov, n_ir, n_ov, s_ir, s_ov;
   logic [31:0] m_od, n_od, s_od;
   logic [1:0]  m_occ, n_occ, s_occ;
   logic [15:0] m_st, n_st;
   logic [3:0]  s_st;

   pipe_stage_elastic #(.DATA_W(32), .SKID_EN(1), .CNT_W(16)) dut_main (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(m_ir),
      .in_data(in_data), .out_valid(m_ov), .out_ready(out_ready), .out_data(m_od),
      .occupancy(m_occ), .stall_cnt(m_st));

   pipe_stage_elastic #(.DATA_W(32), .SKID_EN(0), .CNT_W(16)) dut_noskid (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(n_ir),
      .in_data(in_data), .out_valid(n_ov), .out_ready(out_ready), .out_data(n_od),
      .occupancy(n_occ), .stall_cnt(n_st));

   pipe_stage_elastic #(.DATA_W(32), .SKID_EN(1), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_ir),
      .in_data(in_data), .out_valid(s_ov), .out_ready(out_ready), .out_data(s_od),
      .occupancy(s_occ), .stall_cnt(s_st));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        rst, flush, iv;
      logic [31:0] d;
      logic        ordy;
      logic        sel;
      logic        ir, ov;
      logic [31:0] od;
      logic [1:0]  occ;
      logic [15:0] st;
   } vec_t;

   vec_t        vt[$];
   logic [31:0] taken[$];
   logic [31:0] exp_taken[$];
   bit          rec;
   int          n_cmp;
   int          n_bad;

   function automatic vec_t mk(input logic r, input logic f, input logic v,
                               input logic [31:0] d, input logic o, input logic s,
                               input logic ir, input logic ov, input logic [31:0] od,
                               input logic [1:0] occ, input logic [15:0] st);
      vec_t x;
      x.rst = r; x.flush = f; x.iv = v; x.d = d; x.ordy = o; x.sel = s;
      x.ir = ir; x.ov = ov; x.od = od; x.occ = occ; x.st = st;
      return x;
   endfunction

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   // Record completed downstream transfers of the skid stage.
   always @(negedge clk) begin
      if (rec && !rst && m_ov && out_ready) taken.push_back(m_od);
   end

   initial begin
      vec_t v;
      n_cmp = 0; n_bad = 0; rec = 1'b1;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

      // skid stage: reset, streaming, backpressure, flush, take during flush
      vt.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0));
      for (int k = 0; k < 8; k++) vt.push_back(mk(0,0,1,k,1,0, 1,1,k,1,0));
      vt.push_back(mk(0,0,0,0,1,0,      1,0,0,0,0));
      vt.push_back(mk(0,0,1,'hA,0,0,    1,1,'hA,1,0));
      vt.push_back(mk(0,0,1,'hB,0,0,    1,1,'hA,2,1));
      vt.push_back(mk(0,0,1,'hC,0,0,    0,1,'hA,2,2));
      vt.push_back(mk(0,0,1,'hC,0,0,    0,1,'hA,2,3));
      vt.push_back(mk(0,0,1,'hC,1,0,    0,1,'hB,1,3));
      vt.push_back(mk(0,0,1,'hC,1,0,    1,1,'hC,1,3));
      vt.push_back(mk(0,0,0,0,1,0,      1,0,0,0,3));
      vt.push_back(mk(0,0,1,'h11,0,0,   1,1,'h11,1,3));
      vt.push_back(mk(0,0,1,'h22,0,0,   1,1,'h11,2,4));
      vt.push_back(mk(0,1,1,'h33,1,0,   0,0,0,0,4));
      vt.push_back(mk(0,0,0,0,1,0,      1,0,0,0,4));
      vt.push_back(mk(0,0,1,'h44,0,0,   1,1,'h44,1,4));
      vt.push_back(mk(0,1,0,0,1,0,      0,0,0,0,4));
      // pass-through stage: reset, combinational ready, mid-stream reset
      vt.push_back(mk(1,0,0,0,0,1,      0,0,0,0,0));
      vt.push_back(mk(0,0,1,'h61,1,1,   1,1,'h61,1,0));
      vt.push_back(mk(0,0,1,'h62,0,1,   0,1,'h61,1,1));
      vt.push_back(mk(0,0,1,'h62,1,1,   1,1,'h62,1,1));
      vt.push_back(mk(0,0,1,'h63,1,1,   1,1,'h63,1,1));
      vt.push_back(mk(1,0,1,'h64,0,1,   0,0,0,0,0));
      vt.push_back(mk(0,0,1,'h65,1,1,   1,1,'h65,1,0));
      vt.push_back(mk(0,0,0,0,1,1,      1,0,0,0,0));

      for (int i = 0; i < vt.size(); i++) begin
         v = vt[i];
         if (v.sel) rec = 1'b0;
         rst = v.rst; flush = v.flush; in_valid = v.iv; in_data = v.d; out_ready = v.ordy;
         #1;
         check("in_ready", i, {31'b0, v.sel ? n_ir : m_ir}, {31'b0, v.ir});
         @(posedge clk); #1;
         check("out_valid", i, {31'b0, v.sel ? n_ov : m_ov}, {31'b0, v.ov});
         if (v.ov || v.rst) check("out_data", i, v.sel ? n_od : m_od, v.od);
         check("occupancy", i, {30'b0, v.sel ? n_occ : m_occ}, {30'b0, v.occ});
         check("stall_cnt", i, {16'b0, v.sel ? n_st : m_st}, {16'b0, v.st});
      end

      for (int k = 0; k < 8; k++) exp_taken.push_back(k);
      exp_taken.push_back('hA); exp_taken.push_back('hB); exp_taken.push_back('hC);
      exp_taken.push_back('h11); exp_taken.push_back('h44);
      check("transfer_count", 0, taken.size(), exp_taken.size());
      for (int i = 0; i < exp_taken.size(); i++)
         check("transfer_order", i, (i < taken.size()) ? taken[i] : 32'hDEAD_BEEF, exp_taken[i]);

      // saturation: one beat then a 20-cycle downstream stall
      rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 'h55; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         check("sat_stall_cnt", k, {28'b0, s_st}, (k < 15) ? k : 15);
         check("stalled_data", k, m_od, 'h55);
      end
      check("wide_stall_cnt", 0, {16'b0, m_st}, 20);
      check("stalled_occ", 0, {30'b0, m_occ}, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
